// File: rtl/reset_boot_pkg.sv
// -----------------------------------------------------------------------------
// reset_boot_pkg
// Shared types and helpers for the reset/boot sequencer.
//   boot_state_t : sequencer FSM states (HOLD_SYS, HOLD_CORE, RUN)
//   cnt_width()  : width of a down-counter able to hold max(a, b)
// -----------------------------------------------------------------------------
package reset_boot_pkg;

  typedef enum logic [1:0] {
    HOLD_SYS  = 2'd0,
    HOLD_CORE = 2'd1,
    RUN       = 2'd2
  } boot_state_t;

  // Width needed to store the larger of two cycle counts; never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_boot_system.sv
// -----------------------------------------------------------------------------
// reset_boot_system
// Reset sequencer: after rst (or power-up) holds the system reset (rst_n_o, low)
// for CYCLES edges, then the core reset (rst_core_o, high) for a further
// CORE_CYCLES edges, then flags boot completion and bumps a saturating counter
// of completed boots.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset (clears boot_count_o too)
//   soft_rst_i   : synchronous soft reset, restarts the sequence but keeps
//                  boot_count_o; only used when RESET_BOOT_SOFT_RESET_EN is
//                  defined, otherwise ignored
//   rst_n_o      : system reset, active-low, registered
//   rst_core_o   : core reset, active-high, registered
//   boot_done_o  : high once both resets are released, registered
//   boot_count_o : completed boot sequences, saturating, registered
//
// Configuration macro: RESET_BOOT_SOFT_RESET_EN (enables soft_rst_i).
// -----------------------------------------------------------------------------
module reset_boot_system
  import reset_boot_pkg::*;
#(
  parameter int CYCLES      = 20,  // 1..65535
  parameter int CORE_CYCLES = 4,   // 0..65535
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst_i,
  output logic                   rst_n_o,
  output logic                   rst_core_o,
  output logic                   boot_done_o,
  output logic [COUNT_WIDTH-1:0] boot_count_o
);

  localparam int CW = cnt_width(CYCLES, CORE_CYCLES);

  boot_state_t   state;
  logic [CW-1:0] cnt;
  logic          soft_req;

`ifdef RESET_BOOT_SOFT_RESET_EN
  assign soft_req = soft_rst_i;
`else
  logic unused_soft_rst;
  assign unused_soft_rst = soft_rst_i;
  assign soft_req        = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HOLD_SYS;
      cnt          <= CW'(CYCLES);
      rst_n_o      <= 1'b0;
      rst_core_o   <= 1'b1;
      boot_done_o  <= 1'b0;
      boot_count_o <= '0;
    end else if (soft_req) begin
      // Soft reset wins over every counter transition and freezes the
      // sequence at its start while held; the boot count survives.
      state       <= HOLD_SYS;
      cnt         <= CW'(CYCLES);
      rst_n_o     <= 1'b0;
      rst_core_o  <= 1'b1;
      boot_done_o <= 1'b0;
    end else begin
      case (state)
        HOLD_SYS: begin
          if (cnt == CW'(1)) begin
            // Counter reaches zero on this edge: release system reset.
            rst_n_o <= 1'b1;
            if (CORE_CYCLES == 0) begin
              state       <= RUN;
              rst_core_o  <= 1'b0;
              boot_done_o <= 1'b1;
              if (boot_count_o != '1) boot_count_o <= boot_count_o + COUNT_WIDTH'(1);
            end else begin
              state <= HOLD_CORE;
              cnt   <= CW'(CORE_CYCLES);
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        HOLD_CORE: begin
          if (cnt == CW'(1)) begin
            state       <= RUN;
            rst_core_o  <= 1'b0;
            boot_done_o <= 1'b1;
            if (boot_count_o != '1) boot_count_o <= boot_count_o + COUNT_WIDTH'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        RUN: ;  // outputs hold until rst or soft reset

        default: begin
          // Unreachable encoding: restart the sequence cleanly.
          state       <= HOLD_SYS;
          cnt         <= CW'(CYCLES);
          rst_n_o     <= 1'b0;
          rst_core_o  <= 1'b1;
          boot_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_boot_system.sv
// -----------------------------------------------------------------------------
// tb_reset_boot_system
// Directed bench for reset_boot_system. Three instances share clk/rst/soft:
//   dut    : defaults (CYCLES=20, CORE_CYCLES=4, COUNT_WIDTH=8)
//   dut_c0 : CYCLES=3, CORE_CYCLES=0
//   dut_w2 : CYCLES=2, CORE_CYCLES=1, COUNT_WIDTH=2 (saturation)
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_reset_boot_system;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rst = 1'b0;

  logic       rst_n,    rst_core,    done;
  logic [7:0] count;
  logic       c0_rst_n, c0_rst_core, c0_done;
  logic [7:0] c0_count;
  logic       w2_rst_n, w2_rst_core, w2_done;
  logic [1:0] w2_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_boot_system dut (
    .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
    .rst_n_o(rst_n), .rst_core_o(rst_core),
    .boot_done_o(done), .boot_count_o(count)
  );

  reset_boot_system #(.CYCLES(3), .CORE_CYCLES(0)) dut_c0 (
    .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
    .rst_n_o(c0_rst_n), .rst_core_o(c0_rst_core),
    .boot_done_o(c0_done), .boot_count_o(c0_count)
  );

  reset_boot_system #(.CYCLES(2), .CORE_CYCLES(1), .COUNT_WIDTH(2)) dut_w2 (
    .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
    .rst_n_o(w2_rst_n), .rst_core_o(w2_rst_core),
    .boot_done_o(w2_done), .boot_count_o(w2_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packs {rst_n, rst_core, done} for compact checks.
  function automatic logic [2:0] flags_main();
    return {rst_n, rst_core, done};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset state -------------------------------------------------------
    tick(2);
    check("reset_flags", 32'(flags_main()), 32'b010);
    check("reset_count", 32'(count), 32'd0);
    rst = 1'b0;  // released 1 unit after an edge; next edge is edge 1

    // ---- CYCLES=3 / CORE_CYCLES=0 instance -----------------------------------
    tick(2);
    check("c0_edge2_flags", 32'({c0_rst_n, c0_rst_core, c0_done}), 32'b010);
    tick(1);
    check("c0_edge3_flags", 32'({c0_rst_n, c0_rst_core, c0_done}), 32'b101);
    check("c0_edge3_count", 32'(c0_count), 32'd1);
    check("w2_edge3_count", 32'(w2_count), 32'd1);

    // ---- default sequence ----------------------------------------------------
    tick(16);  // edge 19
    check("edge19_flags", 32'(flags_main()), 32'b010);
    tick(1);   // edge 20
    check("edge20_flags", 32'(flags_main()), 32'b110);
    tick(3);   // edge 23
    check("edge23_flags", 32'(flags_main()), 32'b110);
    check("edge23_count", 32'(count), 32'd0);
    tick(1);   // edge 24
    check("edge24_flags", 32'(flags_main()), 32'b101);
    check("edge24_count", 32'(count), 32'd1);
    tick(5);
    check("run_stable", 32'({flags_main(), count}), {21'd0, 3'b101, 8'd1});

`ifdef RESET_BOOT_SOFT_RESET_EN
    // ---- soft reset held 5 edges while in RUN ----------------------------------
    soft_rst = 1'b1;
    tick(1);
    check("soft_edge1_flags", 32'(flags_main()), 32'b010);
    check("soft_keeps_count", 32'(count), 32'd1);
    tick(4);
    soft_rst = 1'b0;
    tick(19);
    check("soft_edge19_flags", 32'(flags_main()), 32'b010);
    tick(1);
    check("soft_edge20_flags", 32'(flags_main()), 32'b110);
    tick(4);
    check("soft_edge24_flags", 32'(flags_main()), 32'b101);
    check("soft_count_2", 32'(count), 32'd2);
    check("w2_count_2", 32'(w2_count), 32'd2);

    // ---- saturation on the 2-bit counter: 3, 3, 3, 3 ----------------------------
    for (int i = 0; i < 4; i++) begin
      soft_rst = 1'b1;
      tick(1);
      check("w2_soft_done_low", 32'(w2_done), 32'd0);
      soft_rst = 1'b0;
      tick(3);
      check("w2_done", 32'(w2_done), 32'd1);
      check("w2_count_sat", 32'(w2_count), 32'd3);
    end
`else
    // ---- soft_rst_i ignored when the feature is compiled out -------------------
    soft_rst = 1'b1;
    tick(1);
    check("soft_ign_edge1", 32'({flags_main(), count}), {21'd0, 3'b101, 8'd1});
    soft_rst = 1'b0;
    tick(1);
    soft_rst = 1'b1;
    tick(3);
    check("soft_ign_held", 32'({flags_main(), count}), {21'd0, 3'b101, 8'd1});
    check("soft_ign_w2", 32'({w2_rst_n, w2_rst_core, w2_done}), 32'b101);
    soft_rst = 1'b0;
    tick(2);
    check("soft_ign_after", 32'({flags_main(), count}), {21'd0, 3'b101, 8'd1});
`endif

    // ---- asynchronous rst from RUN: immediate, between edges --------------------
    #2;
    rst = 1'b1;
    #1;
    check("async_run_flags", 32'(flags_main()), 32'b010);
    check("async_run_count", 32'(count), 32'd0);
    check("async_c0_flags", 32'({c0_rst_n, c0_rst_core, c0_done}), 32'b010);
    tick(1);
    rst = 1'b0;

    // ---- rst at edge 10 of HOLD_SYS, then full sequence repeats ---------------
    tick(10);
    check("edge10_c0_done", 32'(c0_done), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_c0_flags", 32'({c0_rst_n, c0_rst_core, c0_done}), 32'b010);
    check("mid_flags", 32'(flags_main()), 32'b010);
    tick(1);
    rst = 1'b0;
    tick(19);
    check("rep_edge19_flags", 32'(flags_main()), 32'b010);
    tick(1);
    check("rep_edge20_flags", 32'(flags_main()), 32'b110);
    tick(3);
    check("rep_edge23_flags", 32'(flags_main()), 32'b110);
    tick(1);
    check("rep_edge24_flags", 32'(flags_main()), 32'b101);
    check("rep_edge24_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_boot_system.md
Name: reset_boot_system

Overview:
Reset sequencer for the processor test harness. After external reset or power-up it holds the system reset (active-low) for a fixed number of clock cycles. It then holds the core reset (active-high) for a further number of cycles, and finally flags boot completion. It sits between the board clock and the controller/core, feeding their reset inputs.

Parameters:
CYCLES, 20, clock edges rst_n_o stays low after the sequence starts; legal range 1..65535.
CORE_CYCLES, 4, additional edges rst_core_o stays high after rst_n_o rises; legal range 0..65535.
COUNT_WIDTH, 8, width of the saturating boot counter.

Ports:
clk  input  1  system clock; all sequential logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
soft_rst_i  input  1  synchronous soft-reset request; only effective when RESET_BOOT_SOFT_RESET_EN is defined.
rst_n_o  output  1  system reset, active-low.
rst_core_o  output  1  core reset, active-high.
boot_done_o  output  1  high once both resets are released.
boot_count_o  output  COUNT_WIDTH  number of completed boot sequences, saturating.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on rst.
- FSM states: HOLD_SYS, HOLD_CORE, RUN. A single down-counter is wide enough for max(CYCLES, CORE_CYCLES).
- rst asserted: takes effect immediately and asynchronously. state=HOLD_SYS, counter=CYCLES, rst_n_o=0, rst_core_o=1, boot_done_o=0, boot_count_o=0.
- HOLD_SYS: counter decrements each edge.
  - On the edge where it reaches 0: rst_n_o goes to 1.
  - If CORE_CYCLES=0, go directly to RUN on that same edge.
  - Otherwise go to HOLD_CORE with counter=CORE_CYCLES.
  - Net timing: after rst falls, rst_n_o is low for exactly CYCLES rising edges and high after the CYCLES-th edge.
- HOLD_CORE: counter decrements each edge; when it reaches 0, go to RUN.
- On entering RUN (a single edge):
  - rst_core_o goes to 0 and boot_done_o goes to 1.
  - boot_count_o increments by 1, saturating at 2^COUNT_WIDTH-1.
  - rst_core_o falls exactly CYCLES+CORE_CYCLES edges after rst deassertion.
- RUN: all outputs stable until rst or a soft reset.
- All outputs are registered; no combinational path from inputs to outputs.
- rst asserted mid-sequence: restarts from the rst reset values, including clearing boot_count_o.
- Invalid or unreachable state encodings recover to HOLD_SYS with counter=CYCLES.

Optional Feature:
Macro RESET_BOOT_SOFT_RESET_EN.
- Defined:
  - soft_rst_i sampled high on any edge, in any state: next state HOLD_SYS, counter=CYCLES, rst_n_o=0, rst_core_o=1, boot_done_o=0.
  - boot_count_o is preserved.
  - While soft_rst_i is held high, the sequence stays frozen at the start. Counting begins on the first edge with soft_rst_i low.
  - Soft reset has priority over the normal counter transitions.
- Not defined: soft_rst_i is ignored; the port remains present and unconnected internally.

Decomposition:
- Package reset_boot_pkg holds:
  - the state enum typedef (HOLD_SYS, HOLD_CORE, RUN);
  - a counter-width constant function, max-based $clog2.
- Single module; no sub-module is needed (one FSM plus one counter).

Test Plan:
- Default parameters, rst pulsed then released: rst_n_o low for 20 edges, high after edge 20. rst_core_o falls at edge 24, when boot_done_o=1 and boot_count_o=1.
- rst asserted at edge 10 of HOLD_SYS, between edges: all outputs return to reset values immediately (not waiting for the next edge). After release, the full 20+4 sequence repeats; boot_count_o=1 at completion.
- CORE_CYCLES=0, CYCLES=3: rst_n_o rises, rst_core_o falls and boot_done_o rises on the same edge 3.
- With RESET_BOOT_SOFT_RESET_EN defined, soft_rst_i high for 5 edges while in RUN:
  - next edge: rst_n_o=0, rst_core_o=1, boot_done_o=0;
  - rst_n_o rises 20 edges after soft_rst_i falls;
  - boot_count_o goes 1 -> 2.
- COUNT_WIDTH=2, soft reset repeated 5 times (macro defined): boot_count_o reads 1, 2, 3, 3, 3, 3 (saturation).
- Macro undefined, soft_rst_i toggled in RUN: no output change.
